damage_resolver: RTL and testbench



---
 rtl/damage_resolver_pkg.sv | 42 ++++
 rtl/damage_resolver_health_tracker.sv | 63 ++++++
 rtl/damage_resolver.sv | 136 +++++++++++++
 tb/tb_damage_resolver.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/damage_resolver_pkg.sv
// Shared constants, player/round encodings and the damage lookup for the
// damage resolver and its per-player health trackers.
package damage_resolver_pkg;

  localparam int HEALTH_DEPTH_DEF   = 7;
  localparam int MAX_HEALTH_DEF     = 100;
  localparam int KICK_DAMAGE_DEF    = 10;
  localparam int GRAB_DAMAGE_DEF    = 15;
  localparam int HITSTUN_FRAMES_DEF = 12;
  localparam int KO_FRAMES_DEF      = 60;

  localparam int STATE_DEPTH = 3;

  typedef enum logic [STATE_DEPTH-1:0] {
    PS_IDLE  = 3'd0,
    PS_WALK  = 3'd1,
    PS_KICK  = 3'd2,
    PS_GRAB  = 3'd3,
    PS_BLOCK = 3'd4,
    PS_HURT  = 3'd5
  } player_state_e;

  typedef enum logic [1:0] {
    RS_FIGHT = 2'd0,
    RS_KO    = 2'd1,
    RS_DONE  = 2'd2
  } round_state_e;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;
  localparam logic [1:0] WIN_DRAW = 2'b11;

  // Only kicks and grabs hurt; every other attacker state deals nothing.
  function automatic int damage_for(input logic [STATE_DEPTH-1:0] st,
                                    input int kick, input int grab);
    if (st == PS_KICK) return kick;
    if (st == PS_GRAB) return grab;
    return 0;
  endfunction

endpackage

// File: rtl/damage_resolver_health_tracker.sv
// Per-victim health, hitstun and hit pulse: edge-detects the attacker's
// connect flag and applies saturating damage when the hit is accepted.
module health_tracker
  import damage_resolver_pkg::*;
#(
  parameter int HEALTH_DEPTH   = HEALTH_DEPTH_DEF,
  parameter int MAX_HEALTH     = MAX_HEALTH_DEF,
  parameter int KICK_DAMAGE    = KICK_DAMAGE_DEF,
  parameter int GRAB_DAMAGE    = GRAB_DAMAGE_DEF,
  parameter int HITSTUN_FRAMES = HITSTUN_FRAMES_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    frame_tick,
  input  logic                    connects,
  input  logic [STATE_DEPTH-1:0]  attacker_state,
  input  logic                    accept_enable,
  input  logic                    reload,
  output logic [HEALTH_DEPTH-1:0] health,
  output logic                    hitstun,
  output logic                    hit_pulse
);

  localparam int SW = $clog2(HITSTUN_FRAMES + 1);

  logic                    connects_q;
  logic [SW-1:0]           stun_cnt;
  logic                    accept;
  logic [HEALTH_DEPTH-1:0] damage;
  logic [HEALTH_DEPTH:0]   diff;

  always_comb begin
    damage = HEALTH_DEPTH'(damage_for(attacker_state, KICK_DAMAGE, GRAB_DAMAGE));
    // One extra bit so a borrow shows up as the MSB instead of wrapping.
    diff   = {1'b0, health} - {1'b0, damage};
    accept = connects && !connects_q && accept_enable && (stun_cnt == '0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      health     <= HEALTH_DEPTH'(MAX_HEALTH);
      connects_q <= 1'b0;
      stun_cnt   <= '0;
      hit_pulse  <= 1'b0;
    end else begin
      // Edge register keeps tracking outside FIGHT so held connects never refire.
      connects_q <= connects;
      hit_pulse  <= accept;
      if (reload) begin
        health   <= HEALTH_DEPTH'(MAX_HEALTH);
        stun_cnt <= '0;
      end else if (accept) begin
        health   <= diff[HEALTH_DEPTH] ? '0 : diff[HEALTH_DEPTH-1:0];
        stun_cnt <= SW'(HITSTUN_FRAMES);
      end else if (frame_tick && (stun_cnt != '0)) begin
        stun_cnt <= stun_cnt - 1'b1;
      end
    end
  end

  assign hitstun = (stun_cnt != '0);

endmodule

// File: rtl/damage_resolver.sv
// Round controller: two health trackers plus the FIGHT/KO/DONE round FSM,
// the KO freeze counter and the winner latch.
module damage_resolver
  import damage_resolver_pkg::*;
#(
  parameter int HEALTH_DEPTH   = HEALTH_DEPTH_DEF,
  parameter int MAX_HEALTH     = MAX_HEALTH_DEF,
  parameter int KICK_DAMAGE    = KICK_DAMAGE_DEF,
  parameter int GRAB_DAMAGE    = GRAB_DAMAGE_DEF,
  parameter int HITSTUN_FRAMES = HITSTUN_FRAMES_DEF,
  parameter int KO_FRAMES      = KO_FRAMES_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    frame_tick,
  input  logic                    p1_connects,
  input  logic                    p2_connects,
  input  logic [STATE_DEPTH-1:0]  p1_state,
  input  logic [STATE_DEPTH-1:0]  p2_state,
  input  logic                    restart,
  output logic [HEALTH_DEPTH-1:0] p1_health,
  output logic [HEALTH_DEPTH-1:0] p2_health,
  output logic                    p1_hitstun,
  output logic                    p2_hitstun,
  output logic                    p1_hit_pulse,
  output logic                    p2_hit_pulse,
  output logic                    freeze,
  output logic                    round_over,
  output logic [1:0]              winner,
  output round_state_e            round_state
);

  // Handshake: there is no valid/ready pair here; every input is sampled each
  // clock, and hit pulses are single-cycle strobes with no backpressure.

  localparam int KW = $clog2(KO_FRAMES + 1);
  localparam logic [KW-1:0] KO_LAST = KW'(KO_FRAMES - 1);

  round_state_e  state, state_next;
  logic [KW-1:0] ko_cnt, ko_next;
  logic [1:0]    winner_next;
  logic          accept_enable;
  logic          reload;

  assign accept_enable = (state == RS_FIGHT);
  assign reload        = restart && (state == RS_DONE);

  health_tracker #(
    .HEALTH_DEPTH  (HEALTH_DEPTH),
    .MAX_HEALTH    (MAX_HEALTH),
    .KICK_DAMAGE   (KICK_DAMAGE),
    .GRAB_DAMAGE   (GRAB_DAMAGE),
    .HITSTUN_FRAMES(HITSTUN_FRAMES)
  ) u_p1 (
    .clk           (clk),
    .reset         (reset),
    .frame_tick    (frame_tick),
    .connects      (p2_connects),
    .attacker_state(p2_state),
    .accept_enable (accept_enable),
    .reload        (reload),
    .health        (p1_health),
    .hitstun       (p1_hitstun),
    .hit_pulse     (p1_hit_pulse)
  );

  health_tracker #(
    .HEALTH_DEPTH  (HEALTH_DEPTH),
    .MAX_HEALTH    (MAX_HEALTH),
    .KICK_DAMAGE   (KICK_DAMAGE),
    .GRAB_DAMAGE   (GRAB_DAMAGE),
    .HITSTUN_FRAMES(HITSTUN_FRAMES)
  ) u_p2 (
    .clk           (clk),
    .reset         (reset),
    .frame_tick    (frame_tick),
    .connects      (p1_connects),
    .attacker_state(p1_state),
    .accept_enable (accept_enable),
    .reload        (reload),
    .health        (p2_health),
    .hitstun       (p2_hitstun),
    .hit_pulse     (p2_hit_pulse)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= RS_FIGHT;
      ko_cnt <= '0;
      winner <= WIN_NONE;
    end else begin
      state  <= state_next;
      ko_cnt <= ko_next;
      winner <= winner_next;
    end
  end

  always_comb begin
    state_next  = state;
    ko_next     = ko_cnt;
    winner_next = winner;
    case (state)
      RS_FIGHT: begin
        if ((p1_health == '0) || (p2_health == '0)) begin
          state_next  = RS_KO;
          ko_next     = '0;
          // Bit 1 flags P1 down, bit 0 flags P2 down; both set is a draw.
          winner_next = {p1_health == '0, p2_health == '0};
        end
      end
      RS_KO: begin
        if (frame_tick) begin
          if (ko_cnt == KO_LAST) begin
            state_next = RS_DONE;
            ko_next    = '0;
          end else begin
            ko_next = ko_cnt + 1'b1;
          end
        end
      end
      RS_DONE: begin
        if (restart) begin
          state_next  = RS_FIGHT;
          winner_next = WIN_NONE;
          ko_next     = '0;
        end
      end
      default: state_next = RS_FIGHT;
    endcase
  end

  assign freeze      = (state != RS_FIGHT);
  assign round_over  = (state == RS_DONE);
  assign round_state = state;

endmodule

// File: tb/tb_damage_resolver.sv
// Bench for damage_resolver: directed round scenarios plus random play, checked
// every cycle against a rule-level model and a hit scoreboard.
module tb_damage_resolver;
  import damage_resolver_pkg::*;

  localparam int MAXH   = 100;
  localparam int KICK_D = 10;
  localparam int GRAB_D = 15;
  localparam int STUN   = 12;
  localparam int KOF    = 60;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic       frame_tick = 1'b0;
  logic       p1_connects = 1'b0;
  logic       p2_connects = 1'b0;
  logic [2:0] p1_state = 3'd0;
  logic [2:0] p2_state = 3'd0;
  logic       restart = 1'b0;
  logic [6:0] p1_health, p2_health;
  logic       p1_hitstun, p2_hitstun, p1_hit_pulse, p2_hit_pulse;
  logic       freeze, round_over;
  logic [1:0] winner;
  round_state_e dbg_state;

  damage_resolver dut (
    .clk         (clk),
    .reset       (reset),
    .frame_tick  (frame_tick),
    .p1_connects (p1_connects),
    .p2_connects (p2_connects),
    .p1_state    (p1_state),
    .p2_state    (p2_state),
    .restart     (restart),
    .p1_health   (p1_health),
    .p2_health   (p2_health),
    .p1_hitstun  (p1_hitstun),
    .p2_hitstun  (p2_hitstun),
    .p1_hit_pulse(p1_hit_pulse),
    .p2_hit_pulse(p2_hit_pulse),
    .freeze      (freeze),
    .round_over  (round_over),
    .winner      (winner),
    .round_state (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] exp_q[$];   // {victim (0=P1,1=P2), health after hit}

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual != expected) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Index 0 is victim P1, index 1 is victim P2. Phase 0=fight, 1=KO, 2=done.
  int m_h[2]     = '{MAXH, MAXH};
  int m_stun[2]  = '{0, 0};
  bit m_prev[2]  = '{0, 0};
  bit m_pulse[2] = '{0, 0};
  int m_phase = 0;
  int m_ko    = 0;
  int m_win   = 0;
  bit m_hit[2];
  int m_dmg[2];
  bit atk_conn;
  logic [2:0] atk_st;
  bit do_restart;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int v = 0; v < 2; v++) begin
        m_h[v] = MAXH; m_stun[v] = 0; m_prev[v] = 0; m_pulse[v] = 0;
      end
      m_phase = 0; m_ko = 0; m_win = 0;
    end else begin
      do_restart = 0;
      for (int v = 0; v < 2; v++) begin
        atk_conn = (v == 0) ? p2_connects : p1_connects;
        atk_st   = (v == 0) ? p2_state : p1_state;
        m_hit[v] = atk_conn && !m_prev[v] && (m_phase == 0) && (m_stun[v] == 0);
        m_dmg[v] = (atk_st == PS_KICK) ? KICK_D : (atk_st == PS_GRAB) ? GRAB_D : 0;
        m_prev[v] = atk_conn;
      end
      case (m_phase)
        0: if (m_h[0] == 0 || m_h[1] == 0) begin
             m_phase = 1;
             m_ko    = 0;
             m_win   = (m_h[1] == 0 ? 1 : 0) + (m_h[0] == 0 ? 2 : 0);
           end
        1: if (frame_tick) begin
             m_ko++;
             if (m_ko == KOF) m_phase = 2;
           end
        default: if (restart) begin
             do_restart = 1;
             m_phase = 0;
             m_win   = 0;
           end
      endcase
      for (int v = 0; v < 2; v++) begin
        m_pulse[v] = m_hit[v];
        if (do_restart) begin
          m_h[v] = MAXH;
          m_stun[v] = 0;
        end else if (m_hit[v]) begin
          m_h[v] = (m_h[v] > m_dmg[v]) ? m_h[v] - m_dmg[v] : 0;
          m_stun[v] = STUN;
          exp_q.push_back(8'(v * 128 + m_h[v]));
        end else if (frame_tick && m_stun[v] > 0) begin
          m_stun[v]--;
        end
      end
    end
  end

  // ---------------- monitor ----------------
  task automatic sb_pop(input int victim, input int health);
    logic [7:0] e;
    if (exp_q.size() == 0) begin
      check("sb_unexpected_hit", victim + 1, 0);
    end else begin
      e = exp_q.pop_front();
      check("sb_victim", int'(e[7]), victim);
      check("sb_health", int'(e[6:0]), health);
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      check("p1_health", p1_health, m_h[0]);
      check("p2_health", p2_health, m_h[1]);
      check("p1_hitstun", p1_hitstun, int'(m_stun[0] != 0));
      check("p2_hitstun", p2_hitstun, int'(m_stun[1] != 0));
      check("p1_hit_pulse", p1_hit_pulse, m_pulse[0]);
      check("p2_hit_pulse", p2_hit_pulse, m_pulse[1]);
      check("freeze", freeze, int'(m_phase != 0));
      check("round_over", round_over, int'(m_phase == 2));
      check("winner", winner, m_win);
      if (p1_hit_pulse) sb_pop(0, p1_health);
      if (p2_hit_pulse) sb_pop(1, p2_health);
    end
  end

  // ---------------- driver tasks ----------------
  int tick_div = 0;
  bit rand_tick = 0;

  task automatic clk_n(input int n);
    repeat (n) begin
      @(negedge clk);
      if (rand_tick) begin
        frame_tick = ($urandom_range(0, 1) == 0);
      end else begin
        frame_tick = (tick_div == 2);
        tick_div = (tick_div + 1) % 3;
      end
    end
  endtask

  // One-clock connect from the given attacker, then wait out the victim's hitstun.
  task automatic hit(input int attacker, input logic [2:0] st);
    if (attacker == 1) begin p1_state = st; p1_connects = 1'b1; end
    else begin p2_state = st; p2_connects = 1'b1; end
    clk_n(1);
    p1_connects = 1'b0;
    p2_connects = 1'b0;
    clk_n(40);
  endtask

  task automatic reset_value_checks(input string tag);
    check({tag, "_p1_health"}, p1_health, MAXH);
    check({tag, "_p2_health"}, p2_health, MAXH);
    check({tag, "_hitstun"}, {p1_hitstun, p2_hitstun}, 0);
    check({tag, "_pulses"}, {p1_hit_pulse, p2_hit_pulse}, 0);
    check({tag, "_freeze"}, freeze, 0);
    check({tag, "_round_over"}, round_over, 0);
    check({tag, "_winner"}, winner, 0);
  endtask

  task automatic wait_round_over(input int budget);
    for (int i = 0; i < budget && !round_over; i++) clk_n(1);
    check("round_over_reached", round_over, 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    #2 reset = 1'b0;
    #1 reset_value_checks("reset_init");
    clk_n(3);
    reset = 1'b1;
    clk_n(2);

    // Held kick yields exactly one hit.
    p1_state = PS_KICK;
    p1_connects = 1'b1;
    clk_n(20);
    p1_connects = 1'b0;
    check("held_kick_once", p2_health, 90);
    // Grab during hitstun is ignored.
    p1_state = PS_GRAB;
    p1_connects = 1'b1;
    clk_n(1);
    p1_connects = 1'b0;
    clk_n(1);
    check("grab_in_stun", p2_health, 90);
    clk_n(40);
    hit(1, PS_GRAB);
    check("grab_after_stun", p2_health, 75);

    // Drive P2 to 5, then a lethal kick saturates at 0.
    repeat (4) hit(1, PS_GRAB);
    hit(1, PS_KICK);
    check("p2_at_5", p2_health, 5);
    p1_state = PS_KICK;
    p1_connects = 1'b1;
    clk_n(1);
    check("lethal_no_wrap", p2_health, 0);
    check("freeze_lag", freeze, 0);
    clk_n(1);
    check("freeze_on", freeze, 1);
    check("winner_p1", winner, 1);
    p1_connects = 1'b0;
    restart = 1'b1;
    clk_n(1);
    restart = 1'b0;
    clk_n(1);
    check("restart_in_ko_health", p2_health, 0);
    check("restart_in_ko_freeze", freeze, 1);
    wait_round_over(400);
    check("winner_done", winner, 1);

    // Restart in DONE with connects held high: no hits afterwards.
    p1_connects = 1'b1;
    p2_connects = 1'b1;
    p2_state = PS_KICK;
    clk_n(2);
    restart = 1'b1;
    clk_n(1);
    restart = 1'b0;
    check("restart_p2_health", p2_health, MAXH);
    check("restart_winner", winner, 0);
    check("restart_freeze", freeze, 0);
    clk_n(5);
    check("held_after_restart_p1", p1_health, MAXH);
    check("held_after_restart_p2", p2_health, MAXH);
    p1_connects = 1'b0;
    p2_connects = 1'b0;
    clk_n(2);

    // Trade at 10/10 is a draw.
    repeat (6) begin
      hit(1, PS_GRAB);
      hit(2, PS_GRAB);
    end
    check("pre_trade_p1", p1_health, 10);
    check("pre_trade_p2", p2_health, 10);
    p1_state = PS_KICK;
    p2_state = PS_KICK;
    p1_connects = 1'b1;
    p2_connects = 1'b1;
    clk_n(1);
    p1_connects = 1'b0;
    p2_connects = 1'b0;
    check("trade_p1", p1_health, 0);
    check("trade_p2", p2_health, 0);
    clk_n(1);
    check("trade_draw", winner, 3);

    // Asynchronous reset in the middle of KO.
    clk_n(10);
    #2 reset = 1'b0;
    #1 reset_value_checks("reset_mid_ko");
    clk_n(2);
    reset = 1'b1;
    clk_n(2);

    // Random play, including KOs and random restarts.
    rand_tick = 1;
    repeat (1200) begin
      p1_connects = ($urandom_range(0, 2) == 0);
      p2_connects = ($urandom_range(0, 2) == 0);
      p1_state = 3'($urandom_range(0, 5));
      p2_state = 3'($urandom_range(0, 5));
      restart = ($urandom_range(0, 7) == 0);
      clk_n(1);
    end
    p1_connects = 1'b0;
    p2_connects = 1'b0;
    restart = 1'b0;
    clk_n(5);
    check("sb_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1000000;
    n_errors++;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
